// File: rtl/l1d_refill_ctrl_if.sv
// Memory-side request/response bus of the L1D refill controller.
// The controller is the master; the memory system is the slave.
interface l1d_refill_ctrl_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_write,
        output mem_req_addr,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_write,
        input  mem_req_addr,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/l1d_refill_ctrl.sv
// L1D miss handler: optional dirty-victim writeback, then word-by-word
// block fetch streamed into the data array, one miss at a time.
module l1d_refill_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BLOCK_SIZE = 32,
    localparam int BEATS = BLOCK_SIZE / 4,
    localparam int WORD_IDX_W = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    input  logic                  victim_dirty,
    input  logic [ADDR_WIDTH-1:0] victim_addr,
    output logic [WORD_IDX_W-1:0] victim_rd_word,
    input  logic [DATA_WIDTH-1:0] victim_rd_data,
    l1d_refill_ctrl_if.master     mem,
    output logic                  fill_valid,
    output logic [WORD_IDX_W-1:0] fill_word,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_done,
    output logic                  busy
);
    localparam int OFF_W = $clog2(BLOCK_SIZE);
    localparam int TAG_W = ADDR_WIDTH - OFF_W;
    localparam logic [WORD_IDX_W-1:0] LAST = WORD_IDX_W'(BEATS - 1);
    localparam logic [WORD_IDX_W-1:0] ONE = WORD_IDX_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        WB_REQ,
        RD_REQ,
        RD_WAIT
    } state_t;

    state_t                state;
    state_t                state_nx;
    logic [WORD_IDX_W-1:0] cnt;
    logic [WORD_IDX_W-1:0] cnt_nx;
    logic [TAG_W-1:0]      fill_tag;
    logic [TAG_W-1:0]      victim_tag;
    logic                  accept;
    logic                  resp_hit;
    logic                  fill_valid_q;
    logic                  fill_done_q;
    logic [WORD_IDX_W-1:0] fill_word_q;
    logic [DATA_WIDTH-1:0] fill_data_q;

    assign accept   = (state == IDLE) && miss_valid;
    assign resp_hit = (state == RD_WAIT) && mem.mem_resp_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                fill_tag   <= miss_addr[ADDR_WIDTH-1:OFF_W];
                victim_tag <= victim_addr[ADDR_WIDTH-1:OFF_W];
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (miss_valid) begin
                    state_nx = victim_dirty ? WB_REQ : RD_REQ;
                    cnt_nx   = '0;
                end
            end
            WB_REQ: begin
                if (mem.mem_req_ready) begin
                    if (cnt == LAST) begin
                        state_nx = RD_REQ;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + ONE;
                    end
                end
            end
            RD_REQ: begin
                if (mem.mem_req_ready) state_nx = RD_WAIT;
            end
            RD_WAIT: begin
                if (mem.mem_resp_valid) begin
                    if (cnt == LAST) begin
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = RD_REQ;
                        cnt_nx   = cnt + ONE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Reset forces idle-looking outputs even while state is still mid-refill.
    always_comb begin
        miss_ready        = 1'b0;
        busy              = 1'b1;
        victim_rd_word    = '0;
        mem.mem_req_valid = 1'b0;
        mem.mem_req_write = 1'b0;
        mem.mem_req_addr  = '0;
        mem.mem_req_wdata = '0;
        if (reset) begin
            miss_ready = 1'b1;
            busy       = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    miss_ready = 1'b1;
                    busy       = 1'b0;
                end
                WB_REQ: begin
                    mem.mem_req_valid = 1'b1;
                    mem.mem_req_write = 1'b1;
                    mem.mem_req_addr  = {victim_tag, cnt, 2'b00};
                    mem.mem_req_wdata = victim_rd_data;
                    victim_rd_word    = cnt;
                end
                RD_REQ: begin
                    mem.mem_req_valid = 1'b1;
                    mem.mem_req_addr  = {fill_tag, cnt, 2'b00};
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_valid_q <= 1'b0;
            fill_done_q  <= 1'b0;
            fill_word_q  <= '0;
        end else begin
            fill_valid_q <= resp_hit;
            fill_done_q  <= resp_hit && (cnt == LAST);
            if (resp_hit) fill_word_q <= cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && resp_hit) fill_data_q <= mem.mem_resp_data;
    end

    assign fill_valid = fill_valid_q && !reset;
    assign fill_done  = fill_done_q && !reset;
    assign fill_word  = fill_word_q;
    assign fill_data  = fill_data_q;
endmodule

// File: tb/tb_l1d_refill_ctrl.sv
// Bench for l1d_refill_ctrl: transaction-level model of each refill
// plus directed scenarios with hand-derived latencies and addresses.
module tb_l1d_refill_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic        miss_ready;
    logic [31:0] miss_addr;
    logic        victim_dirty;
    logic [31:0] victim_addr;
    logic [2:0]  victim_rd_word;
    logic [31:0] victim_rd_data;
    logic        fill_valid;
    logic [2:0]  fill_word;
    logic [31:0] fill_data;
    logic        fill_done;
    logic        busy;

    l1d_refill_ctrl_if mem();

    l1d_refill_ctrl dut (
        .clk(clk),
        .reset(reset),
        .miss_valid(miss_valid),
        .miss_ready(miss_ready),
        .miss_addr(miss_addr),
        .victim_dirty(victim_dirty),
        .victim_addr(victim_addr),
        .victim_rd_word(victim_rd_word),
        .victim_rd_data(victim_rd_data),
        .mem(mem),
        .fill_valid(fill_valid),
        .fill_word(fill_word),
        .fill_data(fill_data),
        .fill_done(fill_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  ix;
    } req_t;

    typedef struct {
        logic [2:0]  ix;
        logic [31:0] d;
    } fil_t;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit active = 0;
    int acc_cyc = 0;
    int done_cyc = 0;
    int n_acc = 0;
    int n_wr, n_rd, n_fill;
    bit first_set;
    logic [31:0] first_addr, first_wdata, last_fdata;
    logic [31:0] rbase = 32'hA0;
    logic [31:0] vbase = 32'hD000;
    int stall = 0;
    bit spur = 0;

    req_t rq[$];
    fil_t fq[$];

    assign victim_rd_data = vbase + 32'(victim_rd_word);

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Memory: optional ready stall per request, read data one cycle later.
    initial begin
        bit          hs;
        logic [31:0] ha;
        int          sc;
        sc = 0;
        mem.mem_req_ready  = 1'b1;
        mem.mem_resp_valid = 1'b0;
        mem.mem_resp_data  = '0;
        forever begin
            @(negedge clk);
            hs = mem.mem_req_valid && mem.mem_req_ready
                 && !mem.mem_req_write;
            ha = mem.mem_req_addr;
            @(posedge clk);
            #2;
            mem.mem_resp_valid = hs | spur;
            mem.mem_resp_data  = hs ? rbase + 32'(ha[4:2]) : 32'hDEAD;
            if (!mem.mem_req_valid) begin
                mem.mem_req_ready = 1'b1;
                sc = 0;
            end else if (sc < stall) begin
                mem.mem_req_ready = 1'b0;
                sc++;
            end else begin
                mem.mem_req_ready = 1'b1;
                sc = 0;
            end
        end
    end

    // Model update at posedge, full output comparison at negedge.
    initial begin
        logic [31:0] fb, vb;
        logic [31:0] s_addr, s_wdata;
        bit          s_write;
        bit          stalled;
        req_t        e;
        fil_t        f;
        stalled = 0;
        s_addr = '0;
        s_wdata = '0;
        s_write = 0;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                active = 0;
                rq.delete();
                fq.delete();
                stalled = 0;
            end else if (miss_valid && !active) begin
                fb = miss_addr & 32'hFFFF_FFE0;
                vb = victim_addr & 32'hFFFF_FFE0;
                if (victim_dirty)
                    for (int i = 0; i < 8; i++)
                        rq.push_back('{w: 1'b1, a: vb + 32'(4 * i),
                                       d: vbase + 32'(i), ix: 3'(i)});
                for (int i = 0; i < 8; i++) begin
                    rq.push_back('{w: 1'b0, a: fb + 32'(4 * i),
                                   d: 32'h0, ix: 3'(0)});
                    fq.push_back('{ix: 3'(i), d: rbase + 32'(i)});
                end
                active = 1;
                acc_cyc = cyc;
                n_acc++;
                n_wr = 0;
                n_rd = 0;
                n_fill = 0;
                first_set = 0;
            end
            @(negedge clk);
            if (reset) begin
                chk("rst_req_valid", mem.mem_req_valid, 0);
                chk("rst_fill_valid", fill_valid, 0);
                chk("rst_fill_done", fill_done, 0);
                chk("rst_busy", busy, 0);
                chk("rst_miss_ready", miss_ready, 1);
                chk("rst_victim_word", victim_rd_word, 0);
                stalled = 0;
            end else begin
                if (fill_valid) begin
                    if (fq.size() == 0) begin
                        chk("unexpected_fill", fill_valid, 0);
                    end else begin
                        f = fq.pop_front();
                        chk("fill_word", fill_word, f.ix);
                        chk("fill_data", fill_data, f.d);
                        chk("fill_done", fill_done, fq.size() == 0);
                        n_fill++;
                        last_fdata = fill_data;
                        if (fq.size() == 0) begin
                            active = 0;
                            done_cyc = cyc;
                        end
                    end
                end else begin
                    chk("fill_done_alone", fill_done, 0);
                end
                chk("busy", busy, active);
                chk("miss_ready", miss_ready, !active);
                if (!active) begin
                    chk("idle_victim_word", victim_rd_word, 0);
                    chk("idle_req_valid", mem.mem_req_valid, 0);
                end
                if (stalled) begin
                    chk("stall_valid", mem.mem_req_valid, 1);
                    chk("stall_addr", mem.mem_req_addr, s_addr);
                    chk("stall_wdata", mem.mem_req_wdata, s_wdata);
                    chk("stall_write", mem.mem_req_write, s_write);
                end
                stalled = 0;
                if (mem.mem_req_valid) begin
                    if (rq.size() == 0) begin
                        chk("unexpected_req", mem.mem_req_valid, 0);
                    end else begin
                        e = rq[0];
                        chk("req_write", mem.mem_req_write, e.w);
                        chk("req_addr", mem.mem_req_addr, e.a);
                        chk("req_wdata", mem.mem_req_wdata, e.d);
                        if (e.w) chk("victim_word", victim_rd_word, e.ix);
                        if (mem.mem_req_ready) begin
                            void'(rq.pop_front());
                            if (!first_set) begin
                                first_addr = mem.mem_req_addr;
                                first_wdata = mem.mem_req_wdata;
                                first_set = 1;
                            end
                            if (e.w) n_wr++;
                            else n_rd++;
                        end else begin
                            stalled = 1;
                            s_addr = mem.mem_req_addr;
                            s_wdata = mem.mem_req_wdata;
                            s_write = mem.mem_req_write;
                        end
                    end
                end
            end
        end
    end

    task automatic do_miss(input logic [31:0] ma, input bit d,
                           input logic [31:0] va);
        @(posedge clk);
        #1;
        miss_addr = ma;
        victim_dirty = d;
        victim_addr = va;
        miss_valid = 1;
        @(posedge clk);
        #1;
        miss_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (!active) break;
        end
        chk("refill_in_budget", 32'(active), 0);
    endtask

    initial begin
        int base;
        reset = 1;
        miss_valid = 0;
        miss_addr = '0;
        victim_dirty = 0;
        victim_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        #1;
        chk("post_rst_busy", busy, 0);
        chk("post_rst_ready", miss_ready, 1);

        // Clean miss
        rbase = 32'hA0;
        do_miss(32'h0000_1234, 0, 32'h0);
        wait_idle(60);
        chk("clean_latency", 32'(done_cyc - acc_cyc), 16);
        chk("clean_first_addr", first_addr, 32'h1220);
        chk("clean_last_data", last_fdata, 32'hA7);
        chk("clean_writes", 32'(n_wr), 0);
        chk("clean_fills", 32'(n_fill), 8);

        // Dirty miss
        rbase = 32'hC0;
        do_miss(32'h40, 1, 32'h0000_8000);
        wait_idle(80);
        chk("dirty_latency", 32'(done_cyc - acc_cyc), 24);
        chk("dirty_first_addr", first_addr, 32'h8000);
        chk("dirty_first_wdata", first_wdata, 32'hD000);
        chk("dirty_writes", 32'(n_wr), 8);
        chk("dirty_reads", 32'(n_rd), 8);

        // Backpressure: 3 stall cycles per request
        stall = 3;
        do_miss(32'h2010, 1, 32'h3004);
        wait_idle(300);
        chk("bp_latency", 32'(done_cyc - acc_cyc), 72);
        chk("bp_writes", 32'(n_wr), 8);
        chk("bp_fills", 32'(n_fill), 8);
        stall = 0;

        // miss_valid held: second accept on first idle cycle
        rbase = 32'hA0;
        base = n_acc;
        @(posedge clk);
        #1;
        miss_addr = 32'h7000;
        victim_dirty = 0;
        miss_valid = 1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (n_acc >= base + 2) break;
        end
        chk("two_accepts", 32'(n_acc - base), 2);
        chk("reaccept_gap", 32'(acc_cyc - done_cyc), 1);
        @(posedge clk);
        #1;
        miss_valid = 0;
        wait_idle(60);

        // Spurious responses in IDLE and WB_REQ
        @(posedge clk);
        #1;
        spur = 1;
        repeat (2) @(posedge clk);
        #1;
        spur = 0;
        do_miss(32'h100, 1, 32'h900);
        @(posedge clk);
        #1;
        spur = 1;
        repeat (2) @(posedge clk);
        #1;
        spur = 0;
        wait_idle(80);
        chk("spur_writes", 32'(n_wr), 8);
        chk("spur_fills", 32'(n_fill), 8);

        // Reset in the middle of the fill
        do_miss(32'h1234, 0, 32'h0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (fill_valid && fill_word == 3'd3) break;
        end
        chk("saw_word3", fill_word, 3);
        @(posedge clk);
        #1;
        reset = 1;
        @(negedge clk);
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_fill_valid", fill_valid, 0);
        @(posedge clk);
        #1;
        reset = 0;
        spur = 1;
        @(posedge clk);
        #1;
        spur = 0;
        @(negedge clk);
        #1;
        chk("late_resp_busy", busy, 0);
        chk("late_resp_fill", fill_valid, 0);
        do_miss(32'h5678, 0, 32'h0);
        wait_idle(60);
        chk("restart_first_addr", first_addr, 32'h5660);
        chk("restart_fills", 32'(n_fill), 8);
        chk("restart_latency", 32'(done_cyc - acc_cyc), 16);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end
endmodule

// File: doc/l1d_refill_ctrl.md
Name: l1d_refill_ctrl

Overview:
Miss-handling stage directly downstream of the L1 data cache. On a cache miss it accepts one refill request. If the victim way is dirty, it first writes the victim block back to memory word by word. It then fetches the missing block from memory word by word and streams each word into the cache data array, ending with a completion pulse. It handles one miss at a time; the cache stalls while it is busy.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, word width; fixed at 32 (4-byte words).
BLOCK_SIZE, 32, block size in bytes; must be a power of two and at least 4.
BEATS, BLOCK_SIZE/4, derived; words per block (8 by default).
WORD_IDX_W, $clog2(BEATS), derived; word-index width (3 by default).

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
miss_valid  in  1  cache requests a refill
miss_ready  out  1  high only in IDLE; a refill is accepted when miss_valid && miss_ready
miss_addr  in  ADDR_WIDTH  missing address (any byte within the block)
victim_dirty  in  1  victim block must be written back; sampled at accept
victim_addr  in  ADDR_WIDTH  victim block address; sampled at accept
victim_rd_word  out  WORD_IDX_W  word index read from the victim line
victim_rd_data  in  DATA_WIDTH  combinational read data for victim_rd_word, valid in the same cycle
mem_req_valid  out  1  memory request valid
mem_req_ready  in  1  memory accepts the request
mem_req_write  out  1  1 = write (writeback), 0 = read (fill)
mem_req_addr  out  ADDR_WIDTH  word address of the request
mem_req_wdata  out  DATA_WIDTH  write data
mem_resp_valid  in  1  read data return
mem_resp_data  in  DATA_WIDTH  read data
fill_valid  out  1  registered; write fill_data into word fill_word of the line being filled
fill_word  out  WORD_IDX_W  fill word index
fill_data  out  DATA_WIDTH  fill data
fill_done  out  1  registered one-cycle pulse, coincident with the last fill_valid
busy  out  1  high whenever state is not IDLE

Behaviour:
- States: IDLE, WB_REQ, RD_REQ, RD_WAIT.
- Reset: synchronous, takes priority over everything and applies mid-operation. Next state is IDLE and the word counter is 0.
- Output values during reset and in IDLE: mem_req_valid=0, fill_valid=0, fill_done=0, busy=0, miss_ready=1, victim_rd_word=0.
- Outstanding memory responses after a reset are ignored.
- Accept: in IDLE, when miss_valid is high, register the following:
  - fill base = miss_addr with its low $clog2(BLOCK_SIZE) bits cleared;
  - victim base = victim_addr with the same low bits cleared;
  - the dirty flag.
- After accept, go to WB_REQ if the dirty flag is set, otherwise to RD_REQ. Clear the word counter (cnt).
- WB_REQ:
  - mem_req_valid=1, mem_req_write=1, mem_req_addr = victim base + 4*cnt.
  - victim_rd_word=cnt; mem_req_wdata=victim_rd_data.
  - On mem_req_ready: cnt increments. At cnt==BEATS-1, clear cnt and go to RD_REQ.
  - Writes get no response.
- RD_REQ:
  - mem_req_valid=1, mem_req_write=0, mem_req_addr = fill base + 4*cnt, mem_req_wdata=0.
  - On mem_req_ready, go to RD_WAIT.
- RD_WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid: in the next cycle, fill_valid=1, fill_word=cnt, fill_data=mem_resp_data.
  - If cnt==BEATS-1: fill_done=1 in that same next cycle, state goes to IDLE, cnt goes to 0. Otherwise cnt increments and state goes to RD_REQ.
- Request stability: while mem_req_valid=1 and mem_req_ready=0, addr, wdata and write must hold stable. Valid is never dropped before the handshake.
- Response rules: mem_resp_valid outside RD_WAIT is ignored. A response arrives at earliest the cycle after its request handshake. Only one read is outstanding at a time.
- Word order: ascending, from 0 to BEATS-1. Address arithmetic is modulo 2^ADDR_WIDTH; addresses never cross the block boundary.
- Latency: a clean miss with mem_req_ready=1 and a one-cycle response takes 2*BEATS cycles from accept to fill_done (16 by default). A dirty miss adds BEATS cycles.
- fill_data is held at its last value outside fill_valid; fill_valid/fill_word are valid only when fill_valid=1.

Test Plan:
- Clean miss: miss_addr=0x0000_1234, victim_dirty=0, ready=1, resp = 0xA0+i one cycle after each request → read addrs 0x1220, 0x1224, …, 0x123C; fill_word 0..7 with data 0xA0..0xA7; fill_done on the 8th fill, 16 cycles after accept; no writes issued.
- Dirty miss: victim_addr=0x0000_8000 with victim_rd_data=0xD000+idx, miss_addr=0x40 → 8 writes to 0x8000..0x801C carrying data 0xD000..0xD007, then 8 reads from 0x40..0x5C; fill_done after 24 cycles.
- Backpressure: mem_req_ready low for 3 cycles on each request → mem_req_* stays stable while stalled; every word appears exactly once, in order.
- Busy/accept: miss_valid held high throughout a refill → miss_ready=0 and busy=1 until after fill_done. A second miss is accepted on the first IDLE cycle.
- Spurious response: mem_resp_valid pulses during WB_REQ and IDLE → no fill_valid, cnt unchanged.
- Reset mid-fill: assert reset after fill_word=3 → next cycle IDLE, all outputs at reset values. A late response is ignored. A new miss then starts from word 0.
